// File: rtl/gfx_sched_pkg.sv
// Shared types and slot geometry for the graphics fetch sequencer.
package gfx_sched_pkg;

    typedef struct packed {
        logic [19:0] addr;
        logic        flip;
    } fetch_req_t;

    localparam int unsigned SLOT_LEN = 8;
    localparam int unsigned PHASE_W  = $clog2(SLOT_LEN);

    localparam logic [PHASE_W-1:0] PF_WIN_START = PHASE_W'(0);
    localparam logic [PHASE_W-1:0] MO_WIN_START = PHASE_W'(SLOT_LEN / 2);

    // A window's entry is captured on the cycle whose phase precedes its start.
    function automatic logic [PHASE_W-1:0] phase_before(input logic [PHASE_W-1:0] p);
        return p - PHASE_W'(1);
    endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// One-entry valid/ready holding register; ready is a registered empty flag so the
// slot-start free never reaches ready combinationally.
module fetch_hold_reg
    import gfx_sched_pkg::*;
(
    input  logic       sysclk,
    input  logic       reset_b,
    input  logic       valid,
    output logic       ready,
    input  fetch_req_t req,
    input  logic       take,
    output logic       full,
    output fetch_req_t entry
);

    logic       full_q, full_d;
    fetch_req_t entry_q, entry_d;

    always_comb begin
        full_d  = full_q;
        entry_d = entry_q;
        if (take) begin
            full_d = 1'b0;
        end
        // Accept only when empty at the start of the cycle.
        if (valid && !full_q) begin
            full_d  = 1'b1;
            entry_d = req;
        end
    end

    always_ff @(posedge sysclk or negedge reset_b) begin
        if (!reset_b) begin
            full_q  <= 1'b0;
            entry_q <= '0;
        end else begin
            full_q  <= full_d;
            entry_q <= entry_d;
        end
    end

    assign ready = !full_q;
    assign full  = full_q;
    assign entry = entry_q;

endmodule

// File: rtl/gfx_fetch_sched.sv
// Time-division PF/MO graphic ROM fetch sequencer: one PF and one MO fetch per 8-pixel
// slot, with GLD_b timed ROM_LAT cycles into each window (ROM_LAT legal 1..3).
module gfx_fetch_sched
    import gfx_sched_pkg::*;
#(
    parameter int unsigned ROM_LAT = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               sysclk,
    input  logic               reset_b,
    input  logic               en,
    input  logic               line_start,
    input  logic               clr_stats,
    input  logic               pf_valid,
    output logic               pf_ready,
    input  logic [19:0]        pf_addr,
    input  logic               pf_flip,
    input  logic               mo_valid,
    output logic               mo_ready,
    input  logic [19:0]        mo_addr,
    input  logic               mo_flip,
    output logic [17:0]        MGRA,
    output logic [1:0]         MGRI,
    output logic               MGHF,
    output logic               MATCH_b,
    output logic               MO_v_PF_b,
    output logic               GLD_b,
    output logic [PHASE_W-1:0] phase,
    output logic [CNT_W-1:0]   pf_miss,
    output logic [CNT_W-1:0]   mo_miss
);

    localparam logic [PHASE_W-1:0] PF_GLD_PHASE = PF_WIN_START + PHASE_W'(ROM_LAT);
    localparam logic [PHASE_W-1:0] MO_GLD_PHASE = MO_WIN_START + PHASE_W'(ROM_LAT);

    fetch_req_t pf_req, mo_req, pf_entry, mo_entry;
    logic       pf_full, mo_full;
    logic       pf_start, mo_start, advance;

    logic [PHASE_W-1:0] phase_q, phase_d;
    fetch_req_t         fetch_q, fetch_d;
    logic               match_b_q, match_b_d;
    logic               mo_sel_q, mo_sel_d;
    logic               gld_b_q, gld_b_d;
    logic [CNT_W-1:0]   pf_miss_q, pf_miss_d;
    logic [CNT_W-1:0]   mo_miss_q, mo_miss_d;

    assign pf_req = '{addr: pf_addr, flip: pf_flip};
    assign mo_req = '{addr: mo_addr, flip: mo_flip};

    fetch_hold_reg u_pf_hold (
        .sysclk  (sysclk),
        .reset_b (reset_b),
        .valid   (pf_valid),
        .ready   (pf_ready),
        .req     (pf_req),
        .take    (pf_start),
        .full    (pf_full),
        .entry   (pf_entry)
    );

    fetch_hold_reg u_mo_hold (
        .sysclk  (sysclk),
        .reset_b (reset_b),
        .valid   (mo_valid),
        .ready   (mo_ready),
        .req     (mo_req),
        .take    (mo_start),
        .full    (mo_full),
        .entry   (mo_entry)
    );

    // line_start restarts the PF slot even while sequencing is frozen.
    always_comb begin
        advance  = en && !line_start;
        pf_start = line_start || (advance && (phase_q == phase_before(PF_WIN_START)));
        mo_start = advance && (phase_q == phase_before(MO_WIN_START));

        phase_d = phase_q;
        if (line_start) begin
            phase_d = PF_WIN_START;
        end else if (en) begin
            phase_d = phase_q + PHASE_W'(1);
        end

        // Only a real phase step can enter a load phase, so a frozen or aborted
        // window never issues a second or late load.
        gld_b_d = 1'b1;
        if (advance && ((phase_d == PF_GLD_PHASE) || (phase_d == MO_GLD_PHASE))) begin
            gld_b_d = 1'b0;
        end
    end

    always_comb begin
        fetch_d   = fetch_q;
        match_b_d = match_b_q;
        mo_sel_d  = mo_sel_q;
        pf_miss_d = pf_miss_q;
        mo_miss_d = mo_miss_q;

        if (pf_start) begin
            mo_sel_d  = 1'b0;
            match_b_d = !pf_full;
            fetch_d   = pf_full ? pf_entry : '0;
            if (!pf_full && (pf_miss_q != '1)) begin
                pf_miss_d = pf_miss_q + CNT_W'(1);
            end
        end else if (mo_start) begin
            mo_sel_d  = 1'b1;
            match_b_d = !mo_full;
            fetch_d   = mo_full ? mo_entry : '0;
            if (!mo_full && (mo_miss_q != '1)) begin
                mo_miss_d = mo_miss_q + CNT_W'(1);
            end
        end

        if (clr_stats) begin
            pf_miss_d = '0;
            mo_miss_d = '0;
        end
    end

    always_ff @(posedge sysclk or negedge reset_b) begin
        if (!reset_b) begin
            phase_q   <= PF_WIN_START;
            fetch_q   <= '0;
            match_b_q <= 1'b1;
            mo_sel_q  <= 1'b0;
            gld_b_q   <= 1'b1;
            pf_miss_q <= '0;
            mo_miss_q <= '0;
        end else begin
            phase_q   <= phase_d;
            fetch_q   <= fetch_d;
            match_b_q <= match_b_d;
            mo_sel_q  <= mo_sel_d;
            gld_b_q   <= gld_b_d;
            pf_miss_q <= pf_miss_d;
            mo_miss_q <= mo_miss_d;
        end
    end

    assign MGRA      = fetch_q.addr[17:0];
    assign MGRI      = fetch_q.addr[19:18];
    assign MGHF      = fetch_q.flip;
    assign MATCH_b   = match_b_q;
    assign MO_v_PF_b = mo_sel_q;
    assign GLD_b     = gld_b_q;
    assign phase     = phase_q;
    assign pf_miss   = pf_miss_q;
    assign mo_miss   = mo_miss_q;

endmodule

// File: doc/gfx_fetch_sched.md
Name: gfx_fetch_sched

Overview:
- Time-division fetch sequencer for the graphics ROM/shifter cartridge datapath.
- Takes playfield (PF) and motion-object (MO) fetch requests through valid/ready holding registers.
- Places one PF fetch and one MO fetch on the shared graphic ROM address bus in every 8-pixel slot.
- Drives MO_v_PF_b, MATCH_b, MGHF and a correctly timed GLD_b, so each 8-bit shifter set reloads exactly once per 8 sysclk.

Parameters:
ROM_LAT, 2, sysclk cycles from registered address to valid ROM data at the shifter inputs (two clocked ROM stages); legal 1..3
CNT_W, 8, width of saturating miss counters

Ports:
sysclk  in  1  system clock, all state on rising edge
reset_b  in  1  asynchronous active-low reset
en  in  1  advance slot phase; 0 freezes sequencing
line_start  in  1  synchronous pulse, restarts slot at phase 0
clr_stats  in  1  synchronous clear of miss counters
pf_valid  in  1  PF request valid
pf_ready  out  1  PF holding register empty
pf_addr  in  20  PF graphic address {GRI[1:0], GRA[17:0]}
pf_flip  in  1  PF horizontal flip
mo_valid  in  1  MO request valid
mo_ready  out  1  MO holding register empty
mo_addr  in  20  MO graphic address
mo_flip  in  1  MO horizontal flip
MGRA  out  18  graphic ROM address low
MGRI  out  2  graphic ROM address high
MGHF  out  1  flip for current fetch
MATCH_b  out  1  0 = real fetch, 1 = blank fetch (forces NOROM/CPAL/GCS high)
MO_v_PF_b  out  1  0 = PF fetch, 1 = MO fetch
GLD_b  out  1  active-low shifter load strobe, one cycle
phase  out  3  current output slot phase
pf_miss  out  CNT_W  PF slots started with no request
mo_miss  out  CNT_W  MO slots started with no request

Behaviour:
- Reset (asynchronous, reset_b=0):
  - phase=0, GLD_b=1, MATCH_b=1, MO_v_PF_b=0, MGHF=0, MGRA=0, MGRI=0.
  - pf_ready=mo_ready=1, holding registers empty, miss counters 0.
- Holding registers:
  - Each requester has a 1-entry register {addr, flip}.
  - ready = register empty (registered flag); a request transfers when valid & ready.
  - The register frees when its slot starts.
  - The transfer and free may happen in the same cycle only if ready was 1 at the start of that cycle; there is no combinational path from slot start to ready.
- Phase counter:
  - 3-bit, increments mod 8 each cycle when en=1.
  - line_start=1 forces next phase=0, regardless of en, with priority over increment.
- All outputs are registered and described at the output phase.
- Phase 0..3, PF window:
  - MO_v_PF_b=0.
  - {MGRI, MGRA, MGHF} = captured PF entry, held constant through the window.
  - MATCH_b=0 if an entry was captured at slot start; otherwise MATCH_b=1, address 0, and pf_miss increments (saturating).
- Phase 4..7, MO window: identical, with MO_v_PF_b=1, the MO entry and mo_miss.
- Slot start: the entry is moved from the holding register into the fetch register on the cycle before output phase becomes 0 (PF) or 4 (MO).
- GLD_b:
  - Driven 0 for exactly one cycle at phase==ROM_LAT (PF load) and at phase==4+ROM_LAT (MO load); otherwise 1.
  - Asserted for blank fetches too, so the shifters load transparent data.
  - MO_v_PF_b, MGHF and the address are stable from window start through the GLD_b cycle.
- en=0:
  - Phase and all address/select outputs hold; GLD_b=1.
  - Holding registers still accept requests.
- line_start mid-slot:
  - Any GLD_b not yet issued for the aborted window is suppressed.
  - The aborted fetch entry is discarded and not retried.
  - The next PF slot starts at phase 0 with the current PF holding register.
- clr_stats and a miss in the same cycle: the counter becomes 0; clear wins.
- The window and GLD_b placement make each shifter set load every 8 cycles, with a PF-to-MO offset of 4.

Decomposition:
- Package gfx_sched_pkg holds:
  - typedef fetch_req_t {logic [19:0] addr; logic flip;}
  - localparams PF_WIN_START=0, MO_WIN_START=4, SLOT_LEN=8.
- Sub-module fetch_hold_reg: the 1-entry valid/ready holding register, instantiated once for PF and once for MO.

Test Plan:
- Reset then en=1, no requests.
  - GLD_b low at phases 2 and 6 every slot, MATCH_b=1 throughout.
  - pf_miss and mo_miss each reach 5 after 5 slots; they saturate at 255 after 300 slots.
- Request PF addr 20'hA5A5A, flip=1 and MO addr 20'h01234, flip=0 before phase 0.
  - Phases 0..3: MGRI=2'b10, MGRA=18'h25A5A, MGHF=1, MO_v_PF_b=0, MATCH_b=0, GLD_b=0 at phase 2.
  - Phases 4..7: MGRA=18'h01234, MO_v_PF_b=1, GLD_b=0 at phase 6.
- Back-to-back PF valid held high: pf_ready drops after transfer and rises after slot start; exactly one PF fetch per slot and no entry lost over 16 slots.
- line_start asserted at phase 1: no GLD_b at phase 2 for that window; phase=0 the next cycle; the new PF window shows the holding-register contents.
- en=0 at phase 5 for 10 cycles: outputs frozen, GLD_b=1; resuming gives GLD_b=0 at phase 6.
- ROM_LAT=3: GLD_b low at phases 3 and 7.
- reset_b pulsed low mid-window: all outputs return to reset values immediately, without waiting for sysclk.
